exec_unit: RTL and testbench
============================

EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 SHALL have parameter W, default 64, datapath width in bits.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port in_valid  input  1  operands and codes present this cycle.
REQ-005 SHALL have port in_ready  output  1  unit accepts an operation this cycle.
REQ-006 SHALL have port icode  input  4  Y86-64 instruction code.
REQ-007 SHALL have port ifun  input  4  function or condition code.
REQ-008 SHALL have port aluA  input  W  A operand, output of the A-operand selector.
REQ-009 SHALL have port aluB  input  W  B operand.
REQ-010 SHALL have port out_valid  output  1  result registers hold an unconsumed result.
REQ-011 SHALL have port out_ready  input  1  downstream consumes the result this cycle.
REQ-012 SHALL have port valE  output  W  registered result.
REQ-013 SHALL have port Cnd  output  1  registered condition outcome.
REQ-014 SHALL have port cc  output  3  condition-code register {ZF,SF,OF}.
REQ-015 SHALL have port out_err  output  1  registered illegal-ifun flag for OPq.

Function
REQ-016 Accept SHALL occur on in_valid && in_ready; in_ready = (state==IDLE) && (!out_valid || out_ready).
REQ-017 FSM SHALL have states IDLE and MUL; IDLE->MUL only on accepted OPq with ifun 4 (MUL_EN); MUL->IDLE when the iteration counter reaches W-1.
REQ-018 Non-multiply ops SHALL present their result one cycle after accept (out_valid=1 next edge).
REQ-019 For icode 6 (OPq), valE SHALL be: ifun 0 aluB+aluA; 1 aluB-aluA; 2 aluB&aluA; 3 aluB^aluA; results modulo 2^W.
REQ-020 For all other icodes, valE SHALL be aluB+aluA modulo 2^W.
REQ-021 cc SHALL update only on accepted legal OPq, at the edge the result is registered: ZF=(valE==0), SF=valE[W-1].
REQ-022 OF SHALL be: add, A and B same sign and result sign differs; sub, A and B signs differ and result sign differs from B; logical and multiply, 0.
REQ-023 OPq with ifun outside the legal set SHALL give valE=0, out_err=1, cc unchanged; out_err=0 otherwise.
REQ-024 For icode 2 or 7, Cnd SHALL be evaluated on cc before this operation: ifun 0 1; 1 (SF^OF)|ZF; 2 SF^OF; 3 ZF; 4 !ZF; 5 !(SF^OF); 6 !(SF^OF)&!ZF; 7..F 0.
REQ-025 For other icodes, Cnd SHALL be 0.
REQ-026 out_valid SHALL clear on out_ready when no new result is registered that edge; simultaneous consume and accept SHALL keep out_valid=1 with new values.
REQ-027 valE, Cnd and out_err SHALL hold stable while out_valid && !out_ready.

Reset
REQ-028 On rst_n low, state SHALL be IDLE, out_valid=0, valE=0, Cnd=0, out_err=0, cc=3'b100 (ZF=1).
REQ-029 Reset during MUL SHALL abandon the multiply with no result and no cc update.

Configuration
REQ-030 With EXEC_MUL_EN defined, OPq ifun 4 SHALL be legal: iterative shift-add, one bit per cycle, W cycles in MUL, result = low W bits of aluB*aluA, registered W+1 cycles after accept.
REQ-031 Without EXEC_MUL_EN, ifun 4 SHALL be illegal per REQ-023 and MUL SHALL be unreachable.

Structure
REQ-032 A shared package y86_pkg SHALL hold icode constants, ALU ifun constants, condition ifun constants and the cc bit-index constants.
REQ-033 Multiply iteration SHALL be in sub-module mul_iter, instantiated only under EXEC_MUL_EN.

Verification
REQ-034 Reset release -> out_valid=0, valE=0, cc=100, in_ready=1.
REQ-035 OPq add, aluA=64'h7FFF_FFFF_FFFF_FFFF, aluB=1 -> next cycle valE=64'h8000_0000_0000_0000, cc=011.
REQ-036 OPq sub, aluA=5, aluB=5, then jXX ifun 3 -> valE=0, cc=100, second op Cnd=1.
REQ-037 out_ready=0 for 3 cycles after result -> valE held, in_ready=0; out_ready=1 with in_valid -> back-to-back accept, out_valid stays 1.
REQ-038 EXEC_MUL_EN, OPq ifun 4, aluA=3, aluB=7 -> in_ready=0 for 64 cycles, valE=21 at cycle 65, cc=000.
REQ-039 OPq ifun 9 with cc=010 -> valE=0, out_err=1, cc remains 010.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 constants for the execute stage: instruction codes, ALU and
// condition function codes, condition-code bit positions and the FSM state type.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_AND = 4'h2;
    localparam logic [3:0] ALU_XOR = 4'h3;
    localparam logic [3:0] ALU_MUL = 4'h4;

    localparam logic [3:0] C_YES = 4'h0;
    localparam logic [3:0] C_LE  = 4'h1;
    localparam logic [3:0] C_L   = 4'h2;
    localparam logic [3:0] C_E   = 4'h3;
    localparam logic [3:0] C_NE  = 4'h4;
    localparam logic [3:0] C_GE  = 4'h5;
    localparam logic [3:0] C_G   = 4'h6;

    localparam int CC_ZF = 2;
    localparam int CC_SF = 1;
    localparam int CC_OF = 0;

    typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

    // Condition outcome for cmovXX/jXX evaluated on the {ZF,SF,OF} register.
    function automatic logic cond_eval(input logic [3:0] fn, input logic [2:0] flags);
        logic zf;
        logic lt;
        zf = flags[CC_ZF];
        lt = flags[CC_SF] ^ flags[CC_OF];
        case (fn)
            C_YES:   cond_eval = 1'b1;
            C_LE:    cond_eval = lt | zf;
            C_L:     cond_eval = lt;
            C_E:     cond_eval = zf;
            C_NE:    cond_eval = ~zf;
            C_GE:    cond_eval = ~lt;
            C_G:     cond_eval = ~lt & ~zf;
            default: cond_eval = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier, one multiplier bit per cycle over W cycles.
// prod_next exposes the accumulator after the current step so the caller can
// capture the final product on the edge where last is high.
module mul_iter
    import y86_pkg::*;
#(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         last,
    output logic [W-1:0] prod_next
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    logic [W-1:0]  mplier_r;
    logic [W-1:0]  mcand_r;
    logic [W-1:0]  acc_r;
    logic [CW-1:0] cnt_r;
    logic          busy_r;

    assign last      = busy_r && (cnt_r == CW'(W - 1));
    assign prod_next = acc_r + (mplier_r[0] ? mcand_r : {W{1'b0}});

    // Operand load on start, then one shift-add step per cycle while busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mplier_r <= {W{1'b0}};
            mcand_r  <= {W{1'b0}};
            acc_r    <= {W{1'b0}};
            cnt_r    <= {CW{1'b0}};
            busy_r   <= 1'b0;
        end else if (start) begin
            mplier_r <= a;
            mcand_r  <= b;
            acc_r    <= {W{1'b0}};
            cnt_r    <= {CW{1'b0}};
            busy_r   <= 1'b1;
        end else if (busy_r) begin
            mplier_r <= mplier_r >> 1;
            mcand_r  <= mcand_r << 1;
            acc_r    <= prod_next;
            cnt_r    <= cnt_r + CW'(1);
            busy_r   <= !last;
        end else begin
            busy_r   <= 1'b0;
        end
    end

endmodule

// File: rtl/exec_unit.sv
// Y86-64 execute stage: ALU, condition codes and branch/move condition with a
// valid/ready handshake. Define EXEC_MUL_EN to enable the iterative OPq multiply.
module exec_unit
    import y86_pkg::*;
#(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   icode,
    input  logic [3:0]   ifun,
    input  logic [W-1:0] aluA,
    input  logic [W-1:0] aluB,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] valE,
    output logic         Cnd,
    output logic [2:0]   cc,
    output logic         out_err
);

    state_t       state_r;
    logic         accept_s;
    logic [W-1:0] alu_res_s;
    logic         of_s;
    logic         legal_s;
    logic         is_opq_s;
    logic         mul_start_s;
    logic         cnd_s;
    logic         mul_last_s;
    logic [W-1:0] mul_prod_s;

    assign in_ready = (state_r == S_IDLE) && (!out_valid || out_ready);
    assign accept_s = in_valid && in_ready;

`ifdef EXEC_MUL_EN
    mul_iter #(.W(W)) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (accept_s && mul_start_s),
        .a         (aluA),
        .b         (aluB),
        .last      (mul_last_s),
        .prod_next (mul_prod_s)
    );
`else
    assign mul_last_s = 1'b1;
    assign mul_prod_s = {W{1'b0}};
`endif

    // ALU result, overflow, legality and condition outcome for the offered op.
    always_comb begin
        alu_res_s   = aluB + aluA;
        of_s        = 1'b0;
        legal_s     = 1'b1;
        mul_start_s = 1'b0;
        is_opq_s    = (icode == I_OPQ);
        if (is_opq_s) begin
            case (ifun)
                ALU_ADD: begin
                    alu_res_s = aluB + aluA;
                    of_s = (aluA[W-1] == aluB[W-1]) && (alu_res_s[W-1] != aluA[W-1]);
                end
                ALU_SUB: begin
                    alu_res_s = aluB - aluA;
                    of_s = (aluA[W-1] != aluB[W-1]) && (alu_res_s[W-1] != aluB[W-1]);
                end
                ALU_AND: alu_res_s = aluB & aluA;
                ALU_XOR: alu_res_s = aluB ^ aluA;
`ifdef EXEC_MUL_EN
                ALU_MUL: begin
                    alu_res_s   = {W{1'b0}};
                    mul_start_s = 1'b1;
                end
`endif
                default: begin
                    alu_res_s = {W{1'b0}};
                    legal_s   = 1'b0;
                end
            endcase
        end else begin
            alu_res_s = aluB + aluA;
        end
        if (icode == I_RRMOVQ || icode == I_JXX) begin
            cnd_s = cond_eval(ifun, cc);
        end else begin
            cnd_s = 1'b0;
        end
    end

    // Control FSM plus result, flag and handshake registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= S_IDLE;
            out_valid <= 1'b0;
            valE      <= {W{1'b0}};
            Cnd       <= 1'b0;
            out_err   <= 1'b0;
            cc        <= 3'b100;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (accept_s && mul_start_s) begin
                        // The previous result is either absent or consumed this edge.
                        state_r   <= S_MUL;
                        out_valid <= 1'b0;
                    end else if (accept_s) begin
                        out_valid <= 1'b1;
                        valE      <= alu_res_s;
                        Cnd       <= cnd_s;
                        out_err   <= is_opq_s && !legal_s;
                        if (is_opq_s && legal_s) begin
                            cc <= {alu_res_s == {W{1'b0}}, alu_res_s[W-1], of_s};
                        end else begin
                            cc <= cc;
                        end
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end else begin
                        out_valid <= out_valid;
                    end
                end
                S_MUL: begin
                    if (mul_last_s) begin
                        state_r   <= S_IDLE;
                        out_valid <= 1'b1;
                        valE      <= mul_prod_s;
                        Cnd       <= 1'b0;
                        out_err   <= 1'b0;
                        cc        <= {mul_prod_s == {W{1'b0}}, mul_prod_s[W-1], 1'b0};
                    end else begin
                        state_r   <= S_MUL;
                    end
                end
                default: begin
                    state_r   <= S_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exec_unit.sv
// Directed self-checking bench for exec_unit with hand-computed expectations.
module tb_exec_unit;
    localparam int W = 64;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   icode;
    logic [3:0]   ifun;
    logic [W-1:0] aluA;
    logic [W-1:0] aluB;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] valE;
    logic         Cnd;
    logic [2:0]   cc;
    logic         out_err;

    int checks_r;
    int errors_r;

    exec_unit #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .icode     (icode),
        .ifun      (ifun),
        .aluA      (aluA),
        .aluB      (aluB),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .valE      (valE),
        .Cnd       (Cnd),
        .cc        (cc),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_r++;
        if (obs !== exp) begin
            errors_r++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Offer one op at a negedge, hold it through the accepting posedge, sample #1 later.
    task automatic do_op(input logic [3:0] ic, input logic [3:0] fn,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("ready_timeout", {63'd0, in_ready}, 64'd1);
        icode    = ic;
        ifun     = fn;
        aluA     = a;
        aluB     = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic check_res(input string tag, input logic [63:0] v, input logic [2:0] c,
                             input logic cn, input logic er);
        check({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
        check({tag, "_valE"}, valE, v);
        check({tag, "_cc"}, {61'd0, cc}, {61'd0, c});
        check({tag, "_Cnd"}, {63'd0, Cnd}, {63'd0, cn});
        check({tag, "_err"}, {63'd0, out_err}, {63'd0, er});
    endtask

    initial begin
        checks_r  = 0;
        errors_r  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        icode     = 4'h0;
        ifun      = 4'h0;
        aluA      = 64'd0;
        aluB      = 64'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_valid", {63'd0, out_valid}, 64'd0);
        check("rst_valE", valE, 64'd0);
        check("rst_cc", {61'd0, cc}, 64'd4);
        check("rst_ready", {63'd0, in_ready}, 64'd1);
        check("rst_err", {63'd0, out_err}, 64'd0);

        do_op(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        check_res("add_ovf", 64'h8000_0000_0000_0000, 3'b011, 1'b0, 1'b0);
        do_op(4'h6, 4'h1, 64'd5, 64'd5);
        check_res("sub_zero", 64'd0, 3'b100, 1'b0, 1'b0);
        do_op(4'h7, 4'h3, 64'd10, 64'd20);
        check_res("je_taken", 64'd30, 3'b100, 1'b1, 1'b0);
        do_op(4'h7, 4'h4, 64'd1, 64'd2);
        check_res("jne_not", 64'd3, 3'b100, 1'b0, 1'b0);
        do_op(4'h6, 4'h2, 64'h0000_0000_0000_F0F0, 64'h0000_0000_0000_FF00);
        check_res("and", 64'h0000_0000_0000_F000, 3'b000, 1'b0, 1'b0);
        do_op(4'h6, 4'h3, 64'hFF, 64'hFF);
        check_res("xor_zero", 64'd0, 3'b100, 1'b0, 1'b0);
        do_op(4'h6, 4'h1, 64'd2, 64'd1);
        check_res("sub_neg", 64'hFFFF_FFFF_FFFF_FFFF, 3'b010, 1'b0, 1'b0);
        do_op(4'h7, 4'h2, 64'd0, 64'd0);
        check_res("jl_taken", 64'd0, 3'b010, 1'b1, 1'b0);
        do_op(4'h2, 4'h1, 64'd4, 64'd6);
        check_res("cmovle", 64'd10, 3'b010, 1'b1, 1'b0);
        do_op(4'h7, 4'h6, 64'd0, 64'd0);
        check_res("jg_not", 64'd0, 3'b010, 1'b0, 1'b0);
        do_op(4'h7, 4'h8, 64'd0, 64'd0);
        check_res("jcode8", 64'd0, 3'b010, 1'b0, 1'b0);
        do_op(4'h6, 4'h9, 64'd3, 64'd4);
        check_res("illegal", 64'd0, 3'b010, 1'b0, 1'b1);
        do_op(4'h3, 4'h0, 64'd7, 64'd8);
        check_res("irmov", 64'd15, 3'b010, 1'b0, 1'b0);
        do_op(4'h6, 4'h1, 64'd1, 64'h8000_0000_0000_0000);
        check_res("sub_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 3'b001, 1'b0, 1'b0);
        do_op(4'h7, 4'h5, 64'd0, 64'd0);
        check_res("jge_not", 64'd0, 3'b001, 1'b0, 1'b0);

        // Backpressure: hold the result, then consume and accept on the same edge.
        @(posedge clk);
        #1;
        check("drain_valid", {63'd0, out_valid}, 64'd0);
        out_ready = 1'b0;
        do_op(4'h6, 4'h0, 64'd1, 64'd2);
        check_res("bp_first", 64'd3, 3'b000, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold_valE", valE, 64'd3);
            check("bp_hold_valid", {63'd0, out_valid}, 64'd1);
            check("bp_hold_ready", {63'd0, in_ready}, 64'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        do_op(4'h6, 4'h3, 64'h0F, 64'hF0);
        check_res("b2b", 64'hFF, 3'b000, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("b2b_drain", {63'd0, out_valid}, 64'd0);

`ifdef EXEC_MUL_EN
        begin
            int n;
            do_op(4'h6, 4'h4, 64'd3, 64'd7);
            check("mul_busy", {63'd0, in_ready}, 64'd0);
            n = 0;
            while (!out_valid && n < 200) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("mul_latency", 64'(n), 64'd64);
            check_res("mul", 64'd21, 3'b000, 1'b0, 1'b0);
            do_op(4'h6, 4'h4, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3);
            n = 0;
            while (!out_valid && n < 200) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("mul2_latency", 64'(n), 64'd64);
            check_res("mul_neg", 64'hFFFF_FFFF_FFFF_FFFD, 3'b010, 1'b0, 1'b0);
        end
`else
        do_op(4'h6, 4'h4, 64'd3, 64'd7);
        check_res("mul_off", 64'd0, 3'b000, 1'b0, 1'b1);
        check("mul_off_ready", {63'd0, in_ready}, 64'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks_r, errors_r);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
